pll_lock_sequencer: RTL

Reset/lock sequencer for the system PLL that drives the SDRAM and system clocks. It holds the PLL in reset after power-up and waits for lock with a timeout and bounded retries. Once lock has been stable long enough, it releases a single active-high reset for downstream logic. It also re-runs the sequence on loss of lock or on a software re-lock request, and reports a sticky failure when all retries are exhausted.

---
 rtl/pll_lock_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a stable lock with
// timeout and bounded retries, then releases the downstream reset.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 16,
  parameter int unsigned RETRY_W             = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         sync_q;
  logic               locked_s;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               lock_lost_q, lock_lost_d;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes precedence over the timeout.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_RESET_PLL;
          end
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          lock_lost_d = 1'b1;
          retry_d     = '0;
          state_d     = ST_RESET_PLL;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    // Software re-lock overrides everything and starts a fresh episode quietly.
    if (relock_req) begin
      state_d     = ST_RESET_PLL;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end

    if (relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end

    pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule
